router_pkt_reg: RTL and testbench

//  Datapath register stage of the 1x3 router. Sits directly downstream of the router FSM and upstream of the three output FIFOs.

---
 rtl/router_pkt_reg.sv | 132 +++++++++++++
 tb/tb_router_pkt_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reg.sv
// Datapath register stage of the 1x3 router: header latch, FIFO write steering and
// running XOR parity check. Optional length check enabled by `define ROUTER_REG_LEN_CHECK_EN.
module router_pkt_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] int_par;
  logic [DATA_W-1:0] pkt_par;
  logic              hold_par;
  logic              done_q;
  logic              mismatch;

  // The FIFO_FULL state freezes the datapath simply by not being acted on.
  logic unused_full_state;
  assign unused_full_state = full_state;

  // One-hot flags decoded in dout priority order so overlapping flags stay deterministic.
  logic hdr_ok, lfd_wr, ld_wr, ld_park, laf_wr, done_rise;
  assign hdr_ok    = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign lfd_wr    = lfd_state;
  assign ld_wr     = !lfd_state && ld_state && !fifo_full;
  assign ld_park   = !lfd_state && ld_state && fifo_full;
  assign laf_wr    = !lfd_state && !ld_state && laf_state;
  assign done_rise = parity_done && !done_q;

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int CNT_W = DATA_W - 2;
  logic [CNT_W-1:0] count;
  logic             pay_wr;

  assign pay_wr   = (ld_wr && pkt_valid) || (laf_wr && !hold_par);
  assign mismatch = (int_par != pkt_par) || (count != hdr[DATA_W-1:2]);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (detect_add)
      count <= '0;
    else if (pay_wr && (count != '1))
      count <= count + 1'b1;
  end
`else
  assign mismatch = (int_par != pkt_par);
`endif

  // NOTE: every state register here uses non-blocking assignment so all updates
  // read pre-edge values, e.g. the parity byte and parity_done land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout          <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      hdr           <= '0;
      hold          <= '0;
      hold_par      <= 1'b0;
      int_par       <= '0;
      pkt_par       <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= parity_done;

      if (hdr_ok)
        hdr <= data_in;

      if (lfd_wr)
        dout <= hdr;
      else if (ld_wr)
        dout <= data_in;
      else if (ld_park) begin
        hold     <= data_in;
        hold_par <= !pkt_valid;
      end else if (laf_wr)
        dout <= hold;

      if (detect_add) begin
        int_par     <= '0;
        pkt_par     <= '0;
        parity_done <= 1'b0;
        err         <= 1'b0;
      end else begin
        if (lfd_wr)
          int_par <= int_par ^ hdr;
        else if (ld_wr) begin
          if (pkt_valid)
            int_par <= int_par ^ data_in;
          else begin
            pkt_par     <= data_in;
            parity_done <= 1'b1;
          end
        end else if (laf_wr) begin
          if (!hold_par)
            int_par <= int_par ^ hold;
          else if (!parity_done) begin
            pkt_par     <= hold;
            parity_done <= 1'b1;
          end
          // Parity byte seen but not yet written: still close the packet.
          if (low_pkt_valid && !parity_done)
            parity_done <= 1'b1;
        end

        if (done_rise)
          err <= mismatch;
      end

      if (rst_int_reg)
        low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
        low_pkt_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Scoreboard bench for router_pkt_reg: directed packets push expected outputs,
// a negedge monitor pops and compares. Honours `define ROUTER_REG_LEN_CHECK_EN.
module tb_router_pkt_reg;

  typedef enum logic [2:0] {F_NONE, F_DA, F_LFD, F_LD, F_LAF, F_FULL} flag_e;

  typedef struct {
    int         edge_no;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
  } exp_t;

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam logic LEN_ERR = 1'b1;
`else
  localparam logic LEN_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic       parity_done, low_pkt_valid, err;

  exp_t       sq[$];
  logic [7:0] dq[$];
  int         edge_cnt = 0;
  logic       wr_seen = 1'b0;
  logic       end_chk = 1'b0;
  int         checks = 0;
  int         errors = 0;

  router_pkt_reg #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    wr_seen  <= !reset && (lfd_state || (ld_state && !fifo_full) || laf_state);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %02h expected %02h", name, edge_cnt, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].edge_no <= edge_cnt) begin
      exp_t e;
      e = sq.pop_front();
      check("dout", dout, e.dout);
      check("parity_done", {7'd0, parity_done}, {7'd0, e.pd});
      check("low_pkt_valid", {7'd0, low_pkt_valid}, {7'd0, e.lpv});
      check("err", {7'd0, err}, {7'd0, e.err});
    end
    if (wr_seen) begin
      if (dq.size() == 0)
        check("fifo_write_unexpected", 8'h01, 8'h00);
      else
        check("fifo_write", dout, dq.pop_front());
    end
    if (end_chk) begin
      check("status_queue_drained", 8'(sq.size()), 8'h00);
      check("write_queue_drained", 8'(dq.size()), 8'h00);
    end
  end

  task automatic step(input flag_e f, input logic [7:0] d, input logic pv, ff, rir, rst,
                      input logic [7:0] e_dout, input logic e_pd, e_lpv, e_err);
    exp_t e;
    data_in     = d;
    pkt_valid   = pv;
    fifo_full   = ff;
    rst_int_reg = rir;
    reset       = rst;
    detect_add  = (f == F_DA);
    lfd_state   = (f == F_LFD);
    ld_state    = (f == F_LD);
    laf_state   = (f == F_LAF);
    full_state  = (f == F_FULL);
    e.edge_no = edge_cnt + 1;
    e.dout    = e_dout;
    e.pd      = e_pd;
    e.lpv     = e_lpv;
    e.err     = e_err;
    sq.push_back(e);
    if (!rst && (f == F_LFD || (f == F_LD && !ff) || f == F_LAF))
      dq.push_back(e_dout);
    @(posedge clk);
    #1;
  endtask

  // Header 15 plus payload 11..55 as ld_state writes, dout following each byte.
  task automatic good_payload();
    step(F_LFD, 8'h11, 1, 0, 0, 0, 8'h15, 0, 0, 0);
    step(F_LD,  8'h11, 1, 0, 0, 0, 8'h11, 0, 0, 0);
    step(F_LD,  8'h22, 1, 0, 0, 0, 8'h22, 0, 0, 0);
    step(F_LD,  8'h33, 1, 0, 0, 0, 8'h33, 0, 0, 0);
    step(F_LD,  8'h44, 1, 0, 0, 0, 8'h44, 0, 0, 0);
    step(F_LD,  8'h55, 1, 0, 0, 0, 8'h55, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up reset
    step(F_NONE, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    step(F_NONE, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0);

    // Good packet: 15 ^ 11 ^ 22 ^ 33 ^ 44 ^ 55 = 04
    step(F_DA,   8'h15, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    good_payload();
    step(F_LD,   8'h04, 0, 0, 0, 0, 8'h04, 1, 1, 0);
    step(F_NONE, 8'h00, 0, 0, 1, 0, 8'h04, 1, 0, 0);

    // Bad parity byte 05: err rises one clock after parity_done and holds
    step(F_DA,   8'h15, 1, 0, 0, 0, 8'h04, 0, 0, 0);
    good_payload();
    step(F_LD,   8'h05, 0, 0, 0, 0, 8'h05, 1, 1, 0);
    step(F_NONE, 8'h00, 0, 0, 1, 0, 8'h05, 1, 0, 1);
    step(F_NONE, 8'h00, 0, 0, 0, 0, 8'h05, 1, 0, 1);

    // fifo_full on payload byte 33: parked in hold, dout frozen, replayed by laf
    step(F_DA,   8'h15, 1, 0, 0, 0, 8'h05, 0, 0, 0);
    step(F_LFD,  8'h11, 1, 0, 0, 0, 8'h15, 0, 0, 0);
    step(F_LD,   8'h11, 1, 0, 0, 0, 8'h11, 0, 0, 0);
    step(F_LD,   8'h22, 1, 0, 0, 0, 8'h22, 0, 0, 0);
    step(F_LD,   8'h33, 1, 1, 0, 0, 8'h22, 0, 0, 0);
    step(F_FULL, 8'h44, 1, 1, 0, 0, 8'h22, 0, 0, 0);
    step(F_FULL, 8'h44, 1, 1, 0, 0, 8'h22, 0, 0, 0);
    step(F_LAF,  8'h44, 1, 0, 0, 0, 8'h33, 0, 0, 0);
    step(F_LD,   8'h44, 1, 0, 0, 0, 8'h44, 0, 0, 0);
    step(F_LD,   8'h55, 1, 0, 0, 0, 8'h55, 0, 0, 0);
    step(F_LD,   8'h04, 0, 0, 0, 0, 8'h04, 1, 1, 0);
    step(F_NONE, 8'h00, 0, 0, 1, 0, 8'h04, 1, 0, 0);

    // fifo_full on the parity byte: parity recovered from hold in laf_state
    step(F_DA,   8'h15, 1, 0, 0, 0, 8'h04, 0, 0, 0);
    good_payload();
    step(F_LD,   8'h04, 0, 1, 0, 0, 8'h55, 0, 1, 0);
    step(F_FULL, 8'h04, 0, 1, 0, 0, 8'h55, 0, 1, 0);
    step(F_LAF,  8'h04, 0, 0, 0, 0, 8'h04, 1, 1, 0);
    step(F_NONE, 8'h00, 0, 0, 0, 0, 8'h04, 1, 1, 0);
    step(F_NONE, 8'h00, 0, 0, 1, 0, 8'h04, 1, 0, 0);
    // rst_int_reg beats a simultaneous low_pkt_valid set
    step(F_LD,   8'h04, 0, 0, 1, 0, 8'h04, 1, 0, 0);

    // Reset mid-packet, then hdr/hold/hold_par must read back as zero
    step(F_DA,   8'h15, 1, 0, 0, 0, 8'h04, 0, 0, 0);
    step(F_LFD,  8'h11, 1, 0, 0, 0, 8'h15, 0, 0, 0);
    step(F_LD,   8'h11, 1, 0, 0, 0, 8'h11, 0, 0, 0);
    step(F_LD,   8'h22, 1, 0, 0, 0, 8'h22, 0, 0, 0);
    step(F_LD,   8'h33, 1, 0, 0, 1, 8'h00, 0, 0, 0);
    step(F_LFD,  8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(F_LAF,  8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0);

    // Address 11 not latched; short packet (4 of 5 bytes), parity 15^11^22^33^44 = 51
    step(F_DA,   8'h15, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(F_DA,   8'h17, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    step(F_LFD,  8'h11, 1, 0, 0, 0, 8'h15, 0, 0, 0);
    step(F_LD,   8'h11, 1, 0, 0, 0, 8'h11, 0, 0, 0);
    step(F_LD,   8'h22, 1, 0, 0, 0, 8'h22, 0, 0, 0);
    step(F_LD,   8'h33, 1, 0, 0, 0, 8'h33, 0, 0, 0);
    step(F_LD,   8'h44, 1, 0, 0, 0, 8'h44, 0, 0, 0);
    step(F_LD,   8'h51, 0, 0, 0, 0, 8'h51, 1, 1, 0);
    step(F_NONE, 8'h00, 0, 0, 1, 0, 8'h51, 1, 0, LEN_ERR);
    step(F_NONE, 8'h00, 0, 0, 0, 0, 8'h51, 1, 0, LEN_ERR);

    @(negedge clk);
    end_chk = 1'b1;
    @(negedge clk);
    end_chk = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
